// File: rtl/branch_predictor_pkg.sv
// Shared constants and address-slicing helpers for the branch predictor.
package cpu_bp_pkg;

  // Counter value that predicts taken with the least confidence.
  function automatic int unsigned ctr_weak_taken(input int unsigned w);
    return 32'd1 << (w - 1);
  endfunction

  // Counter value that predicts not-taken with the least confidence (0 when w == 1).
  function automatic int unsigned ctr_weak_not_taken(input int unsigned w);
    return (32'd1 << (w - 1)) - 32'd1;
  endfunction

  // Saturation ceiling of a w-bit counter.
  function automatic int unsigned ctr_max(input int unsigned w);
    return (w >= 32) ? 32'hFFFF_FFFF : (32'd1 << w) - 32'd1;
  endfunction

  // Word-aligned table index; PC bits [1:0] are ignored.
  function automatic logic [63:0] pc_index(input logic [63:0] pc, input int unsigned idx_w);
    return (pc >> 2) & ((64'd1 << idx_w) - 64'd1);
  endfunction

  // Everything above the index field.
  function automatic logic [63:0] pc_tag(input logic [63:0] pc, input int unsigned idx_w);
    return pc >> (idx_w + 2);
  endfunction

endpackage

// File: rtl/branch_predictor_sat_counter.sv
// Saturating up/down counter with synchronous load; load wins over inc/dec.
module sat_counter #(
  parameter int unsigned W               = 2,
  parameter logic [W-1:0] RST_VAL        = '0
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  input  logic         dec,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] value
);

  logic [W-1:0] count_q, count_d;

  // Next value: load, else saturating increment, else saturating decrement.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (inc && !(&count_q)) begin
      count_d = count_q + W'(1);
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  // Counter register, asynchronously reset to RST_VAL.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= RST_VAL;
    end else begin
      count_q <= count_d;
    end
  end

  assign value = count_q;

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry saturating direction counters and perf counters.
module branch_predictor
  import cpu_bp_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned ENTRIES = 64,
  parameter int unsigned CNT_W   = 2,
  parameter int unsigned PERF_W  = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] lookup_pc,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_target,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target,
  input  logic              upd_pred_taken,
  input  logic              clear,
  output logic [PERF_W-1:0] perf_branches,
  output logic [PERF_W-1:0] perf_mispred
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = ADDR_W - IDX_W - 2;
  localparam logic [CNT_W-1:0] CtrWt  = CNT_W'(ctr_weak_taken(CNT_W));
  localparam logic [CNT_W-1:0] CtrWnt = CNT_W'(ctr_weak_not_taken(CNT_W));

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [ADDR_W-1:0]  target_q [ENTRIES];
  logic [CNT_W-1:0]   ctr      [ENTRIES];

  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  logic             up_hit, up_en, up_alloc;

  assign lk_idx = IDX_W'(pc_index(64'(lookup_pc), IDX_W));
  assign lk_tag = TAG_W'(pc_tag(64'(lookup_pc), IDX_W));
  assign up_idx = IDX_W'(pc_index(64'(upd_pc), IDX_W));
  assign up_tag = TAG_W'(pc_tag(64'(upd_pc), IDX_W));

  // Table writes are suppressed when clear coincides with an update.
  assign up_en    = upd_valid && !clear;
  assign up_hit   = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
  assign up_alloc = up_en && !up_hit && upd_taken;

  // Lookup reads registered state only, so same-cycle updates are not visible.
  always_comb begin
    pred_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    pred_taken  = pred_hit && ctr[lk_idx][CNT_W-1];
    pred_target = pred_taken ? target_q[lk_idx] : lookup_pc + ADDR_W'(4);
  end

  // Valid bits: cleared by reset or clear, set on allocation.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
    end else if (clear) begin
      valid_q <= '0;
    end else if (up_alloc) begin
      valid_q[up_idx] <= 1'b1;
    end
  end

  // Tag and target storage; deliberately not reset since valid gates their use.
  always_ff @(posedge clock) begin
    if (up_en && upd_taken) begin
      target_q[up_idx] <= upd_target;
      if (!up_hit) begin
        tag_q[up_idx] <= up_tag;
      end
    end
  end

  for (genvar i = 0; i < ENTRIES; i++) begin : gen_entry
    logic sel;
    assign sel = up_en && (up_idx == IDX_W'(i));

    sat_counter #(
      .W       (CNT_W),
      .RST_VAL (CtrWnt)
    ) u_ctr (
      .clock    (clock),
      .reset    (reset),
      .inc      (sel && up_hit && upd_taken),
      .dec      (sel && up_hit && !upd_taken),
      .load     (clear || (sel && !up_hit && upd_taken)),
      .load_val (clear ? CtrWnt : CtrWt),
      .value    (ctr[i])
    );
  end

  sat_counter #(
    .W       (PERF_W),
    .RST_VAL ('0)
  ) u_perf_branches (
    .clock    (clock),
    .reset    (reset),
    .inc      (upd_valid),
    .dec      (1'b0),
    .load     (1'b0),
    .load_val ('0),
    .value    (perf_branches)
  );

  sat_counter #(
    .W       (PERF_W),
    .RST_VAL ('0)
  ) u_perf_mispred (
    .clock    (clock),
    .reset    (reset),
    .inc      (upd_valid && (upd_taken != upd_pred_taken)),
    .dec      (1'b0),
    .load     (1'b0),
    .load_val ('0),
    .value    (perf_mispred)
  );

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: a reference model predicts every cycle's outputs.
module tb_branch_predictor;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] lookup_pc = '0;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = '0;
  logic        upd_taken = 1'b0;
  logic [31:0] upd_target = '0;
  logic        upd_pred_taken = 1'b0;
  logic        clear = 1'b0;

  logic        pred_hit, pred_taken, pred_hit4, pred_taken4;
  logic [31:0] pred_target, pred_target4;
  logic [31:0] perf_branches, perf_mispred;
  logic [3:0]  perf_branches4, perf_mispred4;

  always #5 clock = ~clock;

  branch_predictor dut (
    .clock          (clock),
    .reset          (reset),
    .lookup_pc      (lookup_pc),
    .pred_hit       (pred_hit),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_taken      (upd_taken),
    .upd_target     (upd_target),
    .upd_pred_taken (upd_pred_taken),
    .clear          (clear),
    .perf_branches  (perf_branches),
    .perf_mispred   (perf_mispred)
  );

  branch_predictor #(.PERF_W(4)) dut_p4 (
    .clock          (clock),
    .reset          (reset),
    .lookup_pc      (lookup_pc),
    .pred_hit       (pred_hit4),
    .pred_taken     (pred_taken4),
    .pred_target    (pred_target4),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_taken      (upd_taken),
    .upd_target     (upd_target),
    .upd_pred_taken (upd_pred_taken),
    .clear          (clear),
    .perf_branches  (perf_branches4),
    .perf_mispred   (perf_mispred4)
  );

  typedef struct {
    logic        hit;
    logic        taken;
    logic [31:0] target;
    logic [31:0] pb;
    logic [31:0] pm;
    logic [3:0]  pb4;
    logic [3:0]  pm4;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state (ENTRIES=64, CNT_W=2).
  logic        m_valid [64];
  logic [23:0] m_tag   [64];
  logic [31:0] m_tgt   [64];
  logic [1:0]  m_ctr   [64];
  logic [31:0] m_pb, m_pm;
  logic [3:0]  m_pb4, m_pm4;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 1'b0;
      m_ctr[i]   = 2'd1;
    end
    m_pb = '0; m_pm = '0; m_pb4 = '0; m_pm4 = '0;
  endtask

  function automatic exp_t model_lookup(input logic [31:0] pc);
    exp_t e;
    int   idx;
    idx      = int'(pc[7:2]);
    e.hit    = m_valid[idx] && (m_tag[idx] == pc[31:8]);
    e.taken  = e.hit && m_ctr[idx][1];
    e.target = e.taken ? m_tgt[idx] : pc + 32'd4;
    e.pb = m_pb; e.pm = m_pm; e.pb4 = m_pb4; e.pm4 = m_pm4;
    return e;
  endfunction

  task automatic model_update(input logic uv, input logic [31:0] pc, input logic t,
                              input logic [31:0] tgt, input logic pt, input logic clr);
    int   idx;
    logic hit;
    idx = int'(pc[7:2]);
    hit = m_valid[idx] && (m_tag[idx] == pc[31:8]);
    if (uv) begin
      if (m_pb != 32'hFFFF_FFFF) m_pb++;
      if (m_pb4 != 4'hF) m_pb4++;
      if (t != pt) begin
        if (m_pm != 32'hFFFF_FFFF) m_pm++;
        if (m_pm4 != 4'hF) m_pm4++;
      end
    end
    if (clr) begin
      for (int i = 0; i < 64; i++) begin
        m_valid[i] = 1'b0;
        m_ctr[i]   = 2'd1;
      end
    end else if (uv) begin
      if (hit && t) begin
        if (m_ctr[idx] != 2'd3) m_ctr[idx]++;
        m_tgt[idx] = tgt;
      end else if (hit) begin
        if (m_ctr[idx] != 2'd0) m_ctr[idx]--;
      end else if (t) begin
        m_valid[idx] = 1'b1;
        m_tag[idx]   = pc[31:8];
        m_tgt[idx]   = tgt;
        m_ctr[idx]   = 2'd2;
      end
    end
  endtask

  task automatic compare_outputs(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      check_eq({tag, "_sb_empty"}, 64'd0, 64'd1);
      return;
    end
    e = exp_q.pop_front();
    check_eq({tag, "_hit"},    64'(pred_hit),      64'(e.hit));
    check_eq({tag, "_taken"},  64'(pred_taken),    64'(e.taken));
    check_eq({tag, "_target"}, 64'(pred_target),   64'(e.target));
    check_eq({tag, "_pb"},     64'(perf_branches), 64'(e.pb));
    check_eq({tag, "_pm"},     64'(perf_mispred),  64'(e.pm));
    check_eq({tag, "_pb4"},    64'(perf_branches4), 64'(e.pb4));
    check_eq({tag, "_pm4"},    64'(perf_mispred4),  64'(e.pm4));
  endtask

  // One cycle: drive, check pre-edge outputs against the model, then advance the model.
  task automatic step(input string tag, input logic [31:0] lpc, input logic uv,
                      input logic [31:0] upc, input logic t, input logic [31:0] tgt,
                      input logic pt, input logic clr);
    @(negedge clock);
    lookup_pc = lpc; upd_valid = uv; upd_pc = upc; upd_taken = t;
    upd_target = tgt; upd_pred_taken = pt; clear = clr;
    exp_q.push_back(model_lookup(lpc));
    #1;
    compare_outputs(tag);
    model_update(uv, upc, t, tgt, pt, clr);
  endtask

  task automatic look(input string tag, input logic [31:0] lpc);
    step(tag, lpc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic upd(input string tag, input logic [31:0] lpc, input logic [31:0] upc,
                     input logic t, input logic [31:0] tgt, input logic pt);
    step(tag, lpc, 1'b1, upc, t, tgt, pt, 1'b0);
  endtask

  initial begin
    logic [31:0] pcs [4];
    pcs[0] = 32'h100; pcs[1] = 32'h200; pcs[2] = 32'h144; pcs[3] = 32'h1044;

    model_reset();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;

    look("reset", 32'h100);

    // Allocation; same-cycle lookup still sees the miss.
    upd("alloc_same", 32'h100, 32'h100, 1'b1, 32'h200, 1'b0);
    look("alloc_next", 32'h100);

    // Walk the counter down to saturation at 0.
    for (int i = 0; i < 3; i++) upd("nt_walk", 32'h100, 32'h100, 1'b0, 32'h0, 1'b1);
    look("nt_sat", 32'h100);

    // Walk up to saturation at 3, then one not-taken keeps predicting taken.
    for (int i = 0; i < 4; i++) upd("t_walk", 32'h100, 32'h100, 1'b1, 32'h240, 1'b0);
    upd("t_sat_dec", 32'h100, 32'h100, 1'b0, 32'h0, 1'b1);
    look("t_sat_after", 32'h100);

    // Aliasing: same index, different tag replaces the occupant.
    upd("alias", 32'h200, 32'h200, 1'b1, 32'h300, 1'b1);
    look("alias_old", 32'h100);
    look("alias_new", 32'h200);

    // Clear beats a same-cycle allocate; lookup in that cycle still sees old state.
    step("clear_same", 32'h200, 1'b1, 32'h100, 1'b1, 32'h500, 1'b0, 1'b1);
    look("clear_100", 32'h100);
    look("clear_200", 32'h200);

    // Mixed traffic over a few aliasing and non-aliasing PCs.
    for (int i = 0; i < 40; i++) begin
      step("mixed", pcs[$urandom_range(0, 3)], 1'($urandom_range(0, 1)),
           pcs[$urandom_range(0, 3)], 1'($urandom_range(0, 1)),
           32'h1000 + 32'($urandom_range(0, 255)) * 4, 1'($urandom_range(0, 1)), 1'b0);
    end

    // Saturate the 4-bit perf counters.
    for (int i = 0; i < 20; i++) upd("mispred", 32'h144, 32'h144, 1'b1, 32'h600, 1'b0);
    look("perf_sat", 32'h144);

    // Address wraparound on the fall-through target.
    look("wrap", 32'hFFFF_FFFC);

    // Asynchronous reset in mid-cycle drops all state at once.
    upd("pre_rst", 32'h48, 32'h48, 1'b1, 32'h700, 1'b0);
    look("pre_rst_hit", 32'h48);
    @(negedge clock);
    lookup_pc = 32'h48; upd_valid = 1'b1; upd_pc = 32'h48; upd_taken = 1'b1;
    upd_target = 32'h800; upd_pred_taken = 1'b0; clear = 1'b0;
    #2;
    reset = 1'b0;
    model_reset();
    exp_q.push_back(model_lookup(32'h48));
    #1;
    compare_outputs("async_rst");
    @(negedge clock);
    upd_valid = 1'b0;
    reset = 1'b1;
    look("post_rst", 32'h48);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Parametrised branch predictor for the 5-stage MIPS32 pipeline. It pairs a direct-mapped branch target buffer (BTB) with per-entry saturating direction counters. The IF stage queries it with the current PC and gets a predicted next PC in the same cycle. EX/MEM-stage branch resolution trains it on the following clock edge. It also keeps saturating performance counters for resolved branches and mispredictions.

## Interface
Parameters:
- ADDR_W, 32, PC width in bits.
- ENTRIES, 64, number of BTB entries. Power of two, at least 2.
- CNT_W, 2, width of each direction counter. At least 1.
- PERF_W, 32, width of each performance counter.

Ports:
- clock  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- lookup_pc  in  ADDR_W  PC currently being fetched.
- pred_hit  out  1  lookup_pc hits a valid BTB entry.
- pred_taken  out  1  prediction is taken.
- pred_target  out  ADDR_W  predicted next PC.
- upd_valid  in  1  a conditional branch resolved this cycle.
- upd_pc  in  ADDR_W  PC of the resolved branch.
- upd_taken  in  1  actual outcome of the branch.
- upd_target  in  ADDR_W  actual taken target of the branch.
- upd_pred_taken  in  1  the prediction that was issued for this branch, carried down the pipeline.
- clear  in  1  synchronous invalidate of all entries, e.g. on context change.
- perf_branches  out  PERF_W  number of resolved branches.
- perf_mispred  out  PERF_W  number of mispredicted branches.

## Operation
Address fields:
- IDX_W = log2(ENTRIES).
- index = pc[IDX_W+1:2].
- tag = pc[ADDR_W-1:IDX_W+2].
- PC bits [1:0] are ignored.

Per-entry state: valid (1 bit), tag, target (ADDR_W bits), ctr (CNT_W bits).

Lookup (combinational from registered state):
- pred_hit = valid[index] and the stored tag equals the lookup tag.
- pred_taken = pred_hit and ctr MSB set.
- pred_target = stored target when pred_taken; otherwise lookup_pc+4, computed modulo 2^ADDR_W.

Update (rising edge, when upd_valid=1 and clear=0):
- Hit and taken: ctr increments, saturating at 2^CNT_W−1. Target is overwritten with upd_target.
- Hit and not taken: ctr decrements, saturating at 0. Target is unchanged.
- Miss and taken: the entry is allocated, replacing any previous occupant. Valid=1, tag and target are written, ctr = 2^(CNT_W−1) (weakly taken).
- Miss and not taken: no change to the table.

Performance counters:
- perf_branches increments on every upd_valid.
- perf_mispred increments when upd_valid=1 and upd_taken≠upd_pred_taken.
- Both saturate at all-ones.
- Neither is affected by clear.

Clear:
- Every valid bit goes to 0 and every ctr goes to 2^(CNT_W−1)−1.
- Clear takes priority over an update in the same cycle; that update is dropped from the table but still counted in the perf counters.

Reset:
- All valid bits 0; every ctr = 2^(CNT_W−1)−1 (weakly not-taken; 0 when CNT_W=1).
- Performance counters 0.
- Resulting outputs: pred_hit=0, pred_taken=0, pred_target=lookup_pc+4.
- Reset asserted mid-operation discards all state immediately, whatever update is in flight.

## Timing
- Lookup latency 0: outputs follow lookup_pc combinationally within the same cycle.
- Update latency 1: the new state is visible to lookups from the cycle after the edge.
- Lookup and update to the same index in the same cycle: the lookup returns the pre-update state. There is no bypass.
- Back-to-back updates to the same entry on consecutive cycles each apply in order.
- Tags and targets are not reset. Only valid, ctr and the perf counters are reset.

## Structure
- Shared package cpu_bp_pkg holds the counter encoding constants (weakly taken, weakly not-taken, saturation max) as functions of CNT_W, plus the index/tag slicing helpers.
- One sub-module, sat_counter (parameter W; inputs inc, dec, load, load_val; output value), is used both for the direction counters and the perf counters.
- The table is held in flip-flops, not in a Memory instance, because valid and ctr need per-entry clearing.

## Test plan
Defaults ENTRIES=64, CNT_W=2 unless stated.
- Reset, then lookup_pc=0x100 → pred_hit=0, pred_taken=0, pred_target=0x104, perf counters 0.
- Update pc=0x100, taken, target 0x200, pred_taken=0 → next cycle lookup 0x100 gives hit=1, taken=1, target=0x200; perf_branches=1, perf_mispred=1.
- Three not-taken updates on 0x100 → ctr 2→1→0→0 (saturates); lookup gives hit=1, taken=0, target=0x104.
- Aliasing: allocate 0x100, then taken update to 0x200 (same index, different tag) → lookup 0x100 misses; lookup 0x200 hits with the new target.
- Update pc=0x100 with upd_taken=1 and upd_pred_taken=0, asserted together with clear=1 → 0x100 is not allocated (lookup misses next cycle); perf_branches and perf_mispred each increment by 1. Same-cycle lookup with an update to that index returns the old value.
- PERF_W=4: 20 updates with upd_taken≠upd_pred_taken → both counters hold 15. Separately, lookup_pc=0xFFFFFFFC on a miss → pred_target=0x0.
